// File: rtl/mem_store_buffer.sv
// Store buffer ahead of the data memory: queues stores, drains one per
// idle cycle, gives loads the port and forwards the youngest matching store.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_fwd,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [DW-1:0]              mem_rdata,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_hit;
    logic [DW-1:0] w_fwd_data;
    logic [PW-1:0] w_idx;

    assign st_ready = (r_count != CNT_FULL);
    assign sb_empty = (r_count == '0);
    assign sb_count = r_count;
    assign w_push   = st_valid && st_ready;
    assign w_pop    = (r_count != '0) && !ld_valid;

    // Walk oldest to youngest so the last hit is the youngest match.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (((PW+1)'(i) < r_count) &&
                (r_addr[w_idx][8:1] == ld_addr[8:1])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_data   = '0;
        ld_fwd    = 1'b0;
        if (ld_valid) begin
            mem_read = 1'b1;
            mem_addr = ld_addr;
            ld_fwd   = w_hit;
            ld_data  = w_hit ? w_fwd_data : mem_rdata;
        end else if (w_pop) begin
            mem_write = 1'b1;
            mem_addr  = r_addr[r_head];
            mem_wdata = r_data[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: per-cycle vector table plus a write
// scoreboard against a 256-word memory model.
module tb_mem_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_fwd;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [256];
    logic [31:0] sbq [$];

    always #5 clk = ~clk;

    mem_store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_fwd(ld_fwd),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    assign mem_rdata = mem[mem_addr[8:1]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model and in-order write scoreboard
    always @(posedge clk) begin
        if (rst_n === 1'b1 && mem_write === 1'b1) begin
            mem[mem_addr[8:1]] = mem_wdata;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%h:%h required=none",
                         mem_addr, mem_wdata);
            end else begin
                logic [31:0] e;
                e = sbq.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write_order actual=%h:%h required=%h:%h",
                             mem_addr, mem_wdata, e[31:16], e[15:0]);
                end
            end
        end
    end

    typedef struct {
        logic        sv;
        logic [15:0] sa;
        logic [15:0] sd;
        logic        lv;
        logic [15:0] la;
        logic        rdy;
        logic [2:0]  cnt;
        logic        mw;
        logic [15:0] ma;
        logic [15:0] mwd;
        logic [15:0] ldd;
        logic        fwd;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        input logic sv, input logic [15:0] sa, input logic [15:0] sd,
        input logic lv, input logic [15:0] la, input logic rdy,
        input logic [2:0] cnt, input logic mw, input logic [15:0] ma,
        input logic [15:0] mwd, input logic [15:0] ldd, input logic fwd);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
        v.rdy = rdy; v.cnt = cnt; v.mw = mw; v.ma = ma;
        v.mwd = mwd; v.ldd = ldd; v.fwd = fwd;
        return v;
    endfunction

    task automatic drive(input logic sv, input logic [15:0] sa,
                         input logic [15:0] sd, input logic lv,
                         input logic [15:0] la);
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        // basic drain
        tbl.push_back(mk(1,16'h0010,16'h1234,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,16'h0010,16'h1234,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,16'h0010, 1,0,0,16'h0010,0,16'h1234,0));
        // fill while loads block the drain
        tbl.push_back(mk(1,16'h0100,16'h1111,1,16'h0030, 1,0,0,16'h0030,0,16'hC018,0));
        tbl.push_back(mk(1,16'h0102,16'h2222,1,16'h0030, 1,1,0,16'h0030,0,16'hC018,0));
        tbl.push_back(mk(1,16'h0104,16'h3333,1,16'h0100, 1,2,0,16'h0100,0,16'h1111,1));
        tbl.push_back(mk(1,16'h0106,16'h4444,1,16'h0030, 1,3,0,16'h0030,0,16'hC018,0));
        tbl.push_back(mk(1,16'h0108,16'h5555,1,16'h0030, 0,4,0,16'h0030,0,16'hC018,0));
        tbl.push_back(mk(1,16'h0108,16'h5555,0,0, 0,4,1,16'h0100,16'h1111,0,0));
        tbl.push_back(mk(1,16'h0108,16'h5555,0,0, 1,3,1,16'h0102,16'h2222,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,3,1,16'h0104,16'h3333,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,2,1,16'h0106,16'h4444,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,16'h0108,16'h5555,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0,0));
        // youngest-match forwarding
        tbl.push_back(mk(1,16'h0020,16'hAAAA,1,16'h0040, 1,0,0,16'h0040,0,16'hC020,0));
        tbl.push_back(mk(1,16'h0020,16'hBBBB,1,16'h0040, 1,1,0,16'h0040,0,16'hC020,0));
        tbl.push_back(mk(0,0,0,1,16'h0020, 1,2,0,16'h0020,0,16'hBBBB,1));
        tbl.push_back(mk(0,0,0,0,0, 1,2,1,16'h0020,16'hAAAA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,16'h0020,16'hBBBB,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0,0));
        // word aliasing on addr[8:1]
        tbl.push_back(mk(1,16'h0202,16'h5555,1,16'h0040, 1,0,0,16'h0040,0,16'hC020,0));
        tbl.push_back(mk(0,0,0,1,16'h0002, 1,1,0,16'h0002,0,16'h5555,1));
        tbl.push_back(mk(0,0,0,1,16'h0004, 1,1,0,16'h0004,0,16'hC002,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,16'h0202,16'h5555,0,0));
        tbl.push_back(mk(0,0,0,1,16'h0002, 1,0,0,16'h0002,0,16'h5555,0));
        // same-cycle store and load to one address
        tbl.push_back(mk(1,16'h0030,16'h7777,1,16'h0030, 1,0,0,16'h0030,0,16'hC018,0));
        tbl.push_back(mk(0,0,0,1,16'h0030, 1,1,0,16'h0030,0,16'h7777,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,16'h0030,16'h7777,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0,0));

        #2;
        chk("rst_st_ready", st_ready, 1);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_sb_count", sb_count, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_ld_fwd", ld_fwd, 0);
        chk("rst_ld_data", ld_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            drive(tbl[k].sv, tbl[k].sa, tbl[k].sd, tbl[k].lv, tbl[k].la);
            #2;
            chk($sformatf("v%0d_st_ready", k), st_ready, tbl[k].rdy);
            chk($sformatf("v%0d_sb_count", k), sb_count, tbl[k].cnt);
            chk($sformatf("v%0d_sb_empty", k), sb_empty, tbl[k].cnt == 0);
            chk($sformatf("v%0d_mem_write", k), mem_write, tbl[k].mw);
            chk($sformatf("v%0d_mem_read", k), mem_read, tbl[k].lv);
            chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].ma);
            chk($sformatf("v%0d_mem_wdata", k), mem_wdata, tbl[k].mwd);
            chk($sformatf("v%0d_ld_data", k), ld_data, tbl[k].ldd);
            chk($sformatf("v%0d_ld_fwd", k), ld_fwd, tbl[k].fwd);
            if (tbl[k].sv && tbl[k].rdy)
                sbq.push_back({tbl[k].sa, tbl[k].sd});
        end

        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        #2;
        chk("final_mem_w08", mem[8'h08], 16'h1234);
        chk("final_mem_w80", mem[8'h80], 16'h1111);
        chk("final_mem_w84", mem[8'h84], 16'h5555);
        chk("final_mem_w10", mem[8'h10], 16'hBBBB);
        chk("final_mem_w01", mem[8'h01], 16'h5555);
        chk("final_mem_w18", mem[8'h18], 16'h7777);
        chk("drained_all", sbq.size(), 0);

        // reset mid-operation: three stores held back by loads
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1, 16'h0060 + 16'(2*i), 16'hD000 + 16'(i), 1, 16'h00F0);
            #2;
            chk($sformatf("rq%0d_st_ready", i), st_ready, 1);
            chk($sformatf("rq%0d_sb_count", i), sb_count, 3'(i));
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("rmid_sb_count", sb_count, 0);
        chk("rmid_sb_empty", sb_empty, 1);
        chk("rmid_mem_write", mem_write, 0);
        chk("rmid_st_ready", st_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #3;
            chk($sformatf("post_rst%0d_mem_write", i), mem_write, 0);
            chk($sformatf("post_rst%0d_sb_count", i), sb_count, 0);
        end
        chk("post_rst_mem_w30", mem[8'h30], 16'hC030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
